// File: rtl/dma_master.sv
// Single-channel AHB-Lite DMA master: copies up to 15 words, one NONSEQ read then one NONSEQ
// write per word. Define DMA_MASTER_ERR_ABORT_EN to abort a copy on an HRESP ERROR response.
module dma_master #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        dma_start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dest_addr,
  input  logic [3:0]  transfer_length,
  input  logic        hready_i,
  input  logic [1:0]  hresp_i,
  input  logic [31:0] hrdata_i,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic        hmastlock_o,
  output logic [31:0] hwdata_o,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0]  HtransIdle   = 2'b00;
  localparam logic [1:0]  HtransNonseq = 2'b10;
  localparam logic [31:0] AddrIncr     = 32'(WORD_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        start_acc;
  logic        err_hit;

  assign start_acc = (state_q == StIdle) && dma_start && !start_q;

`ifdef DMA_MASTER_ERR_ABORT_EN
  logic err_q, err_d;

  assign err_hit = ((state_q == StRdData) || (state_q == StWrData)) && (hresp_i == 2'b01);

  // Sticky until the next accepted start.
  always_comb begin
    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (err_hit)   err_d = 1'b1;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_hresp;

  assign unused_hresp = ^hresp_i;
  assign err_hit      = 1'b0;
  assign err          = 1'b0;
`endif

  // State register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_acc) state_d = (transfer_length == 4'd0) ? StFinish : StRdAddr;
      end
      StRdAddr: begin
        if (hready_i) state_d = StRdData;
      end
      StRdData: begin
        if (err_hit)       state_d = StFinish;
        else if (hready_i) state_d = StWrAddr;
      end
      StWrAddr: begin
        if (hready_i) state_d = StWrData;
      end
      StWrData: begin
        if (err_hit)       state_d = StFinish;
        else if (hready_i) state_d = (cnt_q > 4'd1) ? StRdAddr : StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: pointers, remaining count, captured word and start-edge history
  always_comb begin
    start_d = dma_start;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (start_acc) begin
      src_d = src_addr;
      dst_d = dest_addr;
      cnt_d = transfer_length;
    end
    if ((state_q == StRdData) && hready_i && !err_hit) begin
      data_d = hrdata_i;
    end
    if ((state_q == StWrData) && hready_i && !err_hit) begin
      src_d = src_q + AddrIncr;
      dst_d = dst_q + AddrIncr;
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      start_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      start_q <= start_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outputs are decoded from the state so a wait state holds them stable.
  always_comb begin
    haddr_o  = '0;
    htrans_o = HtransIdle;
    hwrite_o = 1'b0;
    hwdata_o = '0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StRdAddr: begin
        htrans_o = HtransNonseq;
        haddr_o  = src_q;
      end
      StRdData: ;
      StWrAddr: begin
        htrans_o = HtransNonseq;
        hwrite_o = 1'b1;
        haddr_o  = dst_q;
      end
      StWrData: hwdata_o = data_q;
      StFinish: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign hsize_o     = 3'b010;
  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_dma_master.sv
// Directed bench for dma_master: a negedge bus monitor acts as slave and scoreboard for the
// expected read/write transactions queued by the main sequence.
module tb_dma_master;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        dma_start;
  logic [31:0] src_addr;
  logic [31:0] dest_addr;
  logic [3:0]  transfer_length;
  logic        hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        busy;
  logic        done;
  logic        err;

  always #5 hclk = ~hclk;

  dma_master #(.WORD_BYTES(4)) dut (
    .hclk            (hclk),
    .hreset_n        (hreset_n),
    .dma_start       (dma_start),
    .src_addr        (src_addr),
    .dest_addr       (dest_addr),
    .transfer_length (transfer_length),
    .hready_i        (hready_i),
    .hresp_i         (hresp_i),
    .hrdata_i        (hrdata_i),
    .haddr_o         (haddr_o),
    .htrans_o        (htrans_o),
    .hwrite_o        (hwrite_o),
    .hsize_o         (hsize_o),
    .hburst_o        (hburst_o),
    .hprot_o         (hprot_o),
    .hmastlock_o     (hmastlock_o),
    .hwdata_o        (hwdata_o),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_rd_q[$];
  xfer_t exp_wr_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] hrdata_v = '0;
  logic [1:0]  hresp_v = 2'b00;
  bit          err_on_read = 1'b0;
  int          hresp_hold = 0;
  bit          wr_pend = 1'b0;
  logic [31:0] wr_addr_v = '0;
  int          nonseq_cnt = 0;
  bit          snap_v = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic [1:0]  snap_trans;
  logic        snap_write;

  assign hrdata_i = hrdata_v;
  assign hresp_i  = hresp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus slave / monitor: sampled mid-cycle, when inputs and outputs are both settled.
  always @(negedge hclk) begin
    bit    rd_acc;
    xfer_t x;
    rd_acc = 1'b0;
    if (!hreset_n) begin
      wr_pend    = 1'b0;
      snap_v     = 1'b0;
      hresp_v    = 2'b00;
      hresp_hold = 0;
    end else begin
      if (snap_v) begin
        check("stall_haddr", haddr_o, snap_addr);
        check("stall_htrans", 32'(htrans_o), 32'(snap_trans));
        check("stall_hwdata", hwdata_o, snap_wdata);
        check("stall_hwrite", 32'(hwrite_o), 32'(snap_write));
      end
      snap_v     = busy && !hready_i;
      snap_addr  = haddr_o;
      snap_trans = htrans_o;
      snap_wdata = hwdata_o;
      snap_write = hwrite_o;
      if (wr_pend && hready_i) begin
        wr_pend = 1'b0;
        check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          x = exp_wr_q.pop_front();
          check("write_addr", wr_addr_v, x.addr);
          check("write_data", hwdata_o, x.data);
        end
      end
      if ((htrans_o == 2'b10) && hready_i) begin
        nonseq_cnt++;
        if (hwrite_o) begin
          wr_pend   = 1'b1;
          wr_addr_v = haddr_o;
        end else begin
          rd_acc = 1'b1;
          check("read_expected", 32'(exp_rd_q.size() != 0), 32'd1);
          if (exp_rd_q.size() != 0) begin
            x = exp_rd_q.pop_front();
            check("read_addr", haddr_o, x.addr);
            hrdata_v = x.data;
          end else begin
            hrdata_v = 32'hDEAD_BEEF;
          end
        end
      end
      // Hold an injected ERROR through the whole following data phase.
      if (rd_acc && err_on_read) begin
        hresp_v     = 2'b01;
        hresp_hold  = 1;
        err_on_read = 1'b0;
      end else if (hresp_hold > 0) begin
        hresp_hold--;
      end else begin
        hresp_v = 2'b00;
      end
    end
  end

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back({src + 32'(4 * i), base + 32'(i)});
      exp_wr_q.push_back({dst + 32'(4 * i), base + 32'(i)});
    end
    src_addr        = src;
    dest_addr       = dst;
    transfer_length = 4'(n);
  endtask

  task automatic do_start();
    dma_start = 1'b0;
    @(posedge hclk);
    #1;
    dma_start = 1'b1;
  endtask

  // Counts edges from the start edge until done is seen; optional 3-cycle stall per phase.
  task automatic wait_done(input int max, input bit stall, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max) begin
      @(posedge hclk);
      cyc++;
      #1;
      if (stall) hready_i = ((cyc % 4) == 0);
      @(negedge hclk);
      if (done) got = 1'b1;
      else if (busy !== 1'b1) check("busy_during", 32'(busy), 32'd1);
    end
    hready_i = 1'b1;
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic finish_xfer(input logic exp_err);
    check("busy_in_finish", 32'(busy), 32'd0);
    @(negedge hclk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("err_flag", 32'(err), 32'(exp_err));
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int n0;
    int spurious;
    hreset_n        = 1'b0;
    dma_start       = 1'b0;
    src_addr        = '0;
    dest_addr       = '0;
    transfer_length = '0;
    hready_i        = 1'b1;
    #1;
    check("rst_haddr", haddr_o, 32'd0);
    check("rst_htrans", 32'(htrans_o), 32'd0);
    check("rst_hwrite", 32'(hwrite_o), 32'd0);
    check("rst_hwdata", hwdata_o, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("const_hsize", 32'(hsize_o), 32'd2);
    check("const_hburst", 32'(hburst_o), 32'd0);
    check("const_hprot", 32'(hprot_o), 32'd3);
    check("const_hmastlock", 32'(hmastlock_o), 32'd0);
    repeat (2) @(posedge hclk);
    #1;
    hreset_n = 1'b1;

    // Three-word copy, zero wait states
    push_copy(32'h100, 32'h200, 3, 32'hA);
    do_start();
    wait_done(60, 1'b0, cyc);
    check("len3_latency", 32'(cyc), 32'd13);
    finish_xfer(1'b0);

    // One word without and with 3-cycle stalls in every phase
    push_copy(32'h400, 32'h500, 1, 32'h55);
    do_start();
    wait_done(40, 1'b0, cyc);
    check("len1_latency", 32'(cyc), 32'd5);
    finish_xfer(1'b0);
    push_copy(32'h400, 32'h500, 1, 32'h66);
    do_start();
    hready_i = 1'b0;
    wait_done(40, 1'b1, cyc);
    check("stall_latency", 32'(cyc), 32'd17);
    finish_xfer(1'b0);

    // Source wraps past the top of the address space; start left high afterwards
    push_copy(32'hFFFF_FFFC, 32'h300, 2, 32'h70);
    do_start();
    wait_done(40, 1'b0, cyc);
    check("wrap_latency", 32'(cyc), 32'd9);
    finish_xfer(1'b0);
    n0       = nonseq_cnt;
    spurious = 0;
    repeat (10) begin
      @(negedge hclk);
      if (busy || done) spurious++;
    end
    check("held_start_no_restart", 32'(spurious), 32'd0);
    check("held_start_no_bus", 32'(nonseq_cnt - n0), 32'd0);

    // ERROR response on the first read of a four-word copy
`ifdef DMA_MASTER_ERR_ABORT_EN
    exp_rd_q.push_back({32'h600, 32'h90});
    src_addr        = 32'h600;
    dest_addr       = 32'h700;
    transfer_length = 4'd4;
    err_on_read     = 1'b1;
    do_start();
    wait_done(40, 1'b0, cyc);
    check("err_latency", 32'(cyc), 32'd3);
    check("err_set", 32'(err), 32'd1);
    finish_xfer(1'b1);
`else
    push_copy(32'h600, 32'h700, 4, 32'h90);
    err_on_read = 1'b1;
    do_start();
    wait_done(40, 1'b0, cyc);
    check("err_ignored_latency", 32'(cyc), 32'd17);
    finish_xfer(1'b0);
`endif

    // Zero-length start: no bus traffic, done right away, err cleared
    n0 = nonseq_cnt;
    src_addr        = 32'h1000;
    dest_addr       = 32'h2000;
    transfer_length = 4'd0;
    do_start();
    wait_done(10, 1'b0, cyc);
    check("len0_latency", 32'(cyc), 32'd1);
    check("len0_no_bus", 32'(nonseq_cnt - n0), 32'd0);
    finish_xfer(1'b0);

    // Reset during the write data phase of word 2 of 5, then a full fresh copy
    push_copy(32'h800, 32'h900, 5, 32'h20);
    do_start();
    repeat (8) @(posedge hclk);
    #1;
    hreset_n  = 1'b0;
    dma_start = 1'b0;
    #1;
    check("abort_rd_progress", 32'(exp_rd_q.size()), 32'd3);
    check("abort_wr_progress", 32'(exp_wr_q.size()), 32'd4);
    check("abort_haddr", haddr_o, 32'd0);
    check("abort_htrans", 32'(htrans_o), 32'd0);
    check("abort_hwdata", hwdata_o, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(negedge hclk);
      if (busy || done) spurious++;
    end
    check("abort_no_done", 32'(spurious), 32'd0);
    push_copy(32'h800, 32'h900, 5, 32'h40);
    do_start();
    wait_done(60, 1'b0, cyc);
    check("len5_latency", 32'(cyc), 32'd21);
    finish_xfer(1'b0);
    dma_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
